// File: rtl/tulip_prog_sequencer.sv
// tulip_prog_sequencer: streams shared programming words to LUT, user FIR and reverb targets, then releases the DSP.
// Optional wait-state timeout enabled by defining TULIP_PROG_SEQ_TIMEOUT_EN.
module tulip_prog_sequencer #(
  parameter int G_LUT_WORDS = 1024,
  parameter int G_USR_TAPS  = 129,
  parameter int G_REV_TAPS  = 1024,
  parameter int G_TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] src_din,
  input  logic        src_din_valid,
  output logic        src_din_ready,
  output logic [23:0] lut_prog_din,
  output logic        lut_prog_din_valid,
  input  logic        lut_prog_din_ready,
  input  logic        lut_prog_din_done,
  output logic [15:0] usr_fir_taps_prog_din,
  output logic        usr_fir_taps_prog_din_valid,
  input  logic        usr_fir_taps_prog_din_ready,
  input  logic        usr_fir_taps_prog_done,
  output logic [15:0] reverb_taps_prog_din,
  output logic        reverb_taps_prog_din_valid,
  input  logic        reverb_taps_prog_din_ready,
  input  logic        reverb_taps_prog_done,
  output logic        dsp_run,
  output logic        busy,
  output logic        error
);
  typedef enum logic [3:0] {IDLE, LD_LUT, WT_LUT, LD_FIR, WT_FIR, LD_REV, WT_REV, RUN, ERR} state_t;
  localparam int MAXW = G_LUT_WORDS > G_USR_TAPS ? (G_LUT_WORDS > G_REV_TAPS ? G_LUT_WORDS : G_REV_TAPS)
                                                 : (G_USR_TAPS > G_REV_TAPS ? G_USR_TAPS : G_REV_TAPS);
  localparam int CW = $clog2(MAXW + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic ld_lut, ld_fir, ld_rev, wt, hs, last, tmo, go;
  assign ld_lut = state == LD_LUT;
  assign ld_fir = state == LD_FIR;
  assign ld_rev = state == LD_REV;
  assign wt = state == WT_LUT || state == WT_FIR || state == WT_REV;
  assign busy = ld_lut | ld_fir | ld_rev | wt;
  assign go = start && (state == IDLE || state == RUN || state == ERR);
  assign lut_prog_din = src_din;
  assign usr_fir_taps_prog_din = src_din[15:0];
  assign reverb_taps_prog_din = src_din[15:0];
  assign lut_prog_din_valid = ld_lut & src_din_valid;
  assign usr_fir_taps_prog_din_valid = ld_fir & src_din_valid;
  assign reverb_taps_prog_din_valid = ld_rev & src_din_valid;
  assign src_din_ready = (ld_lut & lut_prog_din_ready) | (ld_fir & usr_fir_taps_prog_din_ready)
                       | (ld_rev & reverb_taps_prog_din_ready);
  assign hs = src_din_valid & src_din_ready;
  assign last = cnt == (ld_lut ? CW'(G_LUT_WORDS - 1) : ld_fir ? CW'(G_USR_TAPS - 1) : CW'(G_REV_TAPS - 1));
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else
      case (state)
        IDLE, RUN, ERR: state_nxt = go ? LD_LUT : state;
        LD_LUT:         state_nxt = hs && last ? WT_LUT : state;
        WT_LUT:         state_nxt = lut_prog_din_done ? LD_FIR : tmo ? ERR : state;
        LD_FIR:         state_nxt = hs && last ? WT_FIR : state;
        WT_FIR:         state_nxt = usr_fir_taps_prog_done ? LD_REV : tmo ? ERR : state;
        LD_REV:         state_nxt = hs && last ? WT_REV : state;
        WT_REV:         state_nxt = reverb_taps_prog_done ? RUN : tmo ? ERR : state;
        default:        state_nxt = IDLE;
      endcase
  end
  // word counter restarts on every state change, so each LD_x entry begins at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dsp_run <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state_nxt != state ? '0 : hs ? cnt + 1'b1 : cnt;
      dsp_run <= state_nxt == RUN;
    end
`ifdef TULIP_PROG_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(G_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic err_q;
  assign tmo = tcnt == TW'(G_TIMEOUT - 1);
  assign error = err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tcnt <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= wt && state_nxt == state ? tcnt + 1'b1 : '0;
      err_q <= state_nxt == ERR ? 1'b1 : go && !abort ? 1'b0 : err_q;
    end
`else
  assign tmo = G_TIMEOUT < 0;
  assign error = 1'b0;
`endif
endmodule
